// File: rtl/heartbeat_frame_tx.sv
// heartbeat_frame_tx
//
// Liveness/identity beacon. A free-running frame counter is sent on one pin
// as framed Manchester: alternating preamble (first bit 1), a sync symbol
// that is a deliberate Manchester violation (both halves high), the counter
// snapshot MSB first, even parity over the snapshot, then a low idle gap.
// Frames repeat back to back while en is high.
//
// Manchester symbol per bit: half 0 = bit, half 1 = ~bit (1 = high-then-low).
// The line value is XORed with invert before it is registered.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; aborts any frame in flight
//   en           start/continue framing; only looked at on frame boundaries
//   div          half-bit period is div+1 clocks; latched at frame start
//   invert       line polarity; applied on the next registered update
//   signal       registered Manchester line output
//   frame_start  one-cycle registered pulse marking the start of a frame
//   busy         high whenever the sequencer is not idle
//   count        current frame counter value
//
// Handshake: there is no valid/ready pair here. en is a level, sampled only
// when the sequencer is idle or at the last clock of the idle gap; a frame
// that has started always runs to completion unless reset intervenes.
module heartbeat_frame_tx #(
    parameter int WIDTH         = 8,
    parameter int PREAMBLE_BITS = 4,
    parameter int IDLE_BITS     = 2,
    parameter int DIV_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 invert,
    output logic                 signal,
    output logic                 frame_start,
    output logic                 busy,
    output logic [WIDTH-1:0]     count
);

    // Bit index has to cover the longest of the preamble, data and gap runs.
    localparam int MAX_A    = (WIDTH > PREAMBLE_BITS) ? WIDTH : PREAMBLE_BITS;
    localparam int MAX_BITS = (MAX_A > IDLE_BITS) ? MAX_A : IDLE_BITS;
    localparam int IDX_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SYNC,
        S_DATA,
        S_PARITY,
        S_GAP
    } state_t;

    state_t               state_q,       state_d;
    logic [WIDTH-1:0]     cnt_q,         cnt_d;
    logic [WIDTH-1:0]     shift_q,       shift_d;
    logic                 parity_q,      parity_d;
    logic [DIV_WIDTH-1:0] div_q,         div_d;
    logic [DIV_WIDTH-1:0] div_cnt_q,     div_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,     bit_idx_d;
    logic                 half_q,        half_d;
    logic                 signal_q,      signal_d;
    logic                 frame_start_q, frame_start_d;

    logic tick;
    logic last_half;
    logic sym;
    logic start_frame;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        div_d         = div_q;
        div_cnt_d     = div_cnt_q;
        bit_idx_d     = bit_idx_q;
        half_d        = half_q;
        frame_start_d = 1'b0;
        sym           = 1'b0;
        start_frame   = 1'b0;

        tick      = (div_cnt_q == div_q);
        last_half = tick && half_q;

        // Half-bit timing runs in every active state.
        if (tick) begin
            div_cnt_d = '0;
            half_d    = ~half_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                sym       = 1'b0;
                div_cnt_d = '0;
                half_d    = 1'b0;
                if (en) begin
                    start_frame = 1'b1;
                end
            end
            S_PREAMBLE: begin
                // Preamble bit value is 1 on even indices, 0 on odd.
                sym = ~bit_idx_q[0] ^ half_q;
                if (last_half) begin
                    if (bit_idx_q == IDX_W'(PREAMBLE_BITS - 1)) begin
                        state_d   = S_SYNC;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_SYNC: begin
                sym = 1'b1;
                if (last_half) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                sym = shift_q[WIDTH-1] ^ half_q;
                if (last_half) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    if (bit_idx_q == IDX_W'(WIDTH - 1)) begin
                        state_d   = S_PARITY;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                sym = parity_q ^ half_q;
                if (last_half) begin
                    state_d   = S_GAP;
                    bit_idx_d = '0;
                    cnt_d     = cnt_q + WIDTH'(1);
                end
            end
            S_GAP: begin
                sym = 1'b0;
                if (last_half) begin
                    if (bit_idx_q == IDX_W'(IDLE_BITS - 1)) begin
                        if (en) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d   = S_IDLE;
                            bit_idx_d = '0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The counter has already been bumped at the parity->gap step, so a
        // back-to-back frame snapshots the new value.
        if (start_frame) begin
            state_d       = S_PREAMBLE;
            div_d         = div;
            div_cnt_d     = '0;
            half_d        = 1'b0;
            bit_idx_d     = '0;
            shift_d       = cnt_q;
            parity_d      = ^cnt_q;
            frame_start_d = 1'b1;
        end

        signal_d = sym ^ invert;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            div_q         <= '0;
            div_cnt_q     <= '0;
            bit_idx_q     <= '0;
            half_q        <= 1'b0;
            signal_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            div_q         <= div_d;
            div_cnt_q     <= div_cnt_d;
            bit_idx_q     <= bit_idx_d;
            half_q        <= half_d;
            signal_q      <= signal_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign signal      = signal_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != S_IDLE);
    assign count       = cnt_q;

endmodule

// File: tb/tb_heartbeat_frame_tx.sv
module tb_heartbeat_frame_tx;

  localparam int W  = 8;
  localparam int P  = 4;
  localparam int IB = 2;
  localparam int DW = 8;
  localparam int NB = P + 1 + W + 1 + IB;   // bit-times per frame

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] div;
  logic          invert;
  logic          sig;
  logic          fs;
  logic          busy;
  logic [W-1:0]  count;

  always #5 clk = ~clk;

  heartbeat_frame_tx #(
    .WIDTH(W), .PREAMBLE_BITS(P), .IDLE_BITS(IB), .DIV_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .invert(invert),
    .signal(sig), .frame_start(fs), .busy(busy), .count(count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Line level for half-bit h of a frame carrying d, from the frame layout.
  function automatic logic sym_at(input logic [W-1:0] d, input int h);
    int   b;
    logic v;
    b = h / 2;
    if (b < P)              v = (b % 2 == 0);
    else if (b == P)        return 1'b1;
    else if (b <= P + W)    v = d[W - 1 - (b - P - 1)];
    else if (b == P + W + 1) v = ^d;
    else                    return 1'b0;
    return (h % 2 == 1) ? ~v : v;
  endfunction

  logic         m_busy;
  int           m_t;
  int           m_div;
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_data;
  logic         m_sig;
  logic         m_fs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_div  <= 0;
      m_cnt  <= '0;
      m_data <= '0;
      m_sig  <= 1'b0;
      m_fs   <= 1'b0;
    end else begin
      m_sig <= (m_busy ? sym_at(m_data, m_t / (m_div + 1)) : 1'b0) ^ invert;
      m_fs  <= 1'b0;
      if (m_busy) begin
        if (m_t + 1 == (m_div + 1) * 2 * (P + W + 2)) m_cnt <= m_cnt + 1'b1;
        if (m_t + 1 == (m_div + 1) * 2 * NB) begin
          if (en) begin
            m_t    <= 0;
            m_div  <= int'(div);
            m_data <= m_cnt;
            m_fs   <= 1'b1;
          end else begin
            m_busy <= 1'b0;
          end
        end else begin
          m_t <= m_t + 1;
        end
      end else if (en) begin
        m_busy <= 1'b1;
        m_t    <= 0;
        m_div  <= int'(div);
        m_data <= m_cnt;
        m_fs   <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    check("signal", 32'(sig), 32'(m_sig));
    check("frame_start", 32'(fs), 32'(m_fs));
    check("busy", 32'(busy), 32'(m_busy));
    check("count", 32'(count), 32'(m_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Shift in the next 32 samples of the line, first sample ends up in the MSB.
  task automatic capture32(output logic [31:0] v);
    v = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      v = {v[30:0], sig};
    end
  endtask

  task automatic measure_gap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 400);
  endtask

  // Start a frame from IDLE and land on the cycle where frame_start is high.
  task automatic start_en();
    en = 1'b1;
    @(negedge clk);
    check("fs_after_en", 32'(fs), 32'd1);
  endtask

  logic [31:0] cap;
  int          gap;
  int          seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    div    = '0;
    invert = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_signal", 32'(sig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // 1: first two frames at div=0, data 0x00 then 0x01
    start_en();
    capture32(cap);
    check("frame0_bits", cap, 32'h99D5_5550);
    capture32(cap);
    check("frame1_bits", cap, 32'h99D5_55A0);
    check("count_after2", 32'(count), 32'd2);

    // 2: div=2 gives 96-clock frames; div change applies to the next frame
    do_reset();
    div = 8'd2;
    start_en();
    measure_gap(gap);
    check("period_div2", 32'(gap), 32'd96);
    div = 8'd0;
    measure_gap(gap);
    check("period_div2_kept", 32'(gap), 32'd96);
    measure_gap(gap);
    check("period_div0", 32'(gap), 32'd32);

    // 3: counter wrap across 256 frames
    do_reset();
    start_en();
    repeat (32 * 255) @(negedge clk);
    check("count_255", 32'(count), 32'd255);
    capture32(cap);
    check("frame_ff_bits", cap, 32'h99EA_AA90);
    check("count_wrapped", 32'(count), 32'd0);
    capture32(cap);
    check("frame_wrap_bits", cap, 32'h99D5_5550);

    // 4: drop en during DATA of the count=3 frame
    do_reset();
    start_en();
    repeat (32 * 3 + 15) @(negedge clk);
    check("count_3", 32'(count), 32'd3);
    en = 1'b0;
    repeat (60) @(negedge clk);
    check("count_4", 32'(count), 32'd4);
    check("busy_dropped", 32'(busy), 32'd0);
    check("signal_low", 32'(sig), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fs) seen++;
    end
    check("no_fs_while_off", 32'(seen), 32'd0);
    start_en();

    // 5: inverted polarity
    @(negedge clk);
    rst_n  = 1'b0;
    en     = 1'b0;
    invert = 1'b1;
    @(negedge clk);
    check("inv_rst_signal", 32'(sig), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("inv_idle_high", 32'(sig), 32'd1);
    start_en();
    capture32(cap);
    check("inv_frame_bits", cap, 32'h662A_AAAF);
    invert = 1'b0;

    // 6: asynchronous reset in the middle of DATA with count=5
    do_reset();
    start_en();
    repeat (32 * 5 + 14) @(negedge clk);
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_signal", 32'(sig), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_fs", 32'(fs), 32'd0);
    check("async_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_fs", 32'(fs), 32'd1);
    capture32(cap);
    check("restart_bits", cap, 32'h99D5_5550);

    en = 1'b0;
    repeat (40) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/heartbeat_frame_tx.md
Name: heartbeat_frame_tx

Overview:
Parametrised successor to the single-counter Manchester heartbeat. Serialises a free-running frame counter onto one pin as framed Manchester: preamble, sync violation, data MSB-first, even parity, then an idle gap. Adds programmable bit rate, enable, output polarity, framing and status. Sits beside the tile's clock as a liveness/identity beacon that a logic analyser or neighbouring tile can lock onto.

Parameters:
WIDTH, 8, frame counter / data width in bits (>=2)
PREAMBLE_BITS, 4, number of alternating preamble bits (>=1), first bit is 1
IDLE_BITS, 2, gap length in bit-times after parity (>=1)
DIV_WIDTH, 8, width of the half-bit divider input

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  reset; asynchronous, active-low
en  input  1  start/continue framing; sampled at frame boundaries only
div  input  DIV_WIDTH  half-bit period = div+1 clocks; latched at frame start
invert  input  1  XORed into signal at all times after reset
signal  output  1  registered Manchester line output
frame_start  output  1  registered one-cycle pulse when a frame begins
busy  output  1  high whenever state != IDLE
count  output  WIDTH  current frame counter value

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, signal 0, frame_start 0, busy 0, divider and bit index 0. Reset mid-frame aborts the frame immediately; no partial resume.
- States: IDLE -> PREAMBLE -> SYNC -> DATA -> PARITY -> GAP -> (PREAMBLE if en else IDLE).
- Encoding per bit: half 0 = bit, half 1 = ~bit (1 = high-then-low). SYNC is a deliberate violation: both halves high. GAP: line low for 2*IDLE_BITS half-periods. IDLE: line low. The final value is then XORed with invert.
- signal is registered: it shows the symbol/half of the internal state from the previous cycle.
- Half-bit tick: internal divider counts 0..div_q; a tick occurs when it equals div_q, then it reloads 0. Each half-bit lasts exactly div_q+1 clocks. div=0 means one clock per half.
- Frame start (IDLE with en=1 at an edge, or GAP end with en=1): latch div -> div_q, snapshot counter -> shift register, bit index 0, half 0, pulse frame_start the next cycle. From IDLE, the first preamble half-bit appears on signal at the edge after the one that sampled en.
- Back-to-back frames: GAP exits straight to PREAMBLE with no IDLE cycle. The frame period is exactly (div_q+1)*2*(PREAMBLE_BITS+WIDTH+2+IDLE_BITS) clocks.
- DATA: WIDTH bits, MSB first, from the snapshot. The counter may change mid-frame only via reset.
- PARITY: even parity = XOR of the snapshot bits.
- Counter increments by 1 at the PARITY->GAP transition and wraps modulo 2^WIDTH (all-ones -> 0).
- en deasserted mid-frame: the frame completes including GAP and the counter increment, then the block enters IDLE. en re-asserted during GAP of that frame continues seamlessly. en is ignored except at frame boundaries.
- div/invert changes: div takes effect only at the next frame start. invert acts on the next registered signal update (one-cycle latency), including in IDLE.
- busy is combinational from state. busy=0 exactly when state is IDLE.

Test Plan:
1. WIDTH=8, P=4, IDLE=2, div=0, invert=0, en=1 after reset -> frame_start pulse; signal halves 10 01 10 01 | 11 | 01x8 | 01 | 0000 (32 clocks). Then the next frame starts immediately with data 0x01 (..01 01 10), parity 1 (10), count=1.
2. div=2 -> every half-bit held 3 clocks; frame period 96 clocks; changing div to 0 mid-frame leaves the current frame at 3 clocks/half, and the next frame uses 1.
3. WIDTH=4 instance, 16 frames -> count goes 15 -> 0; the frame with data 0xF shows parity 0, and the wrapped frame shows data 0x0.
4. Drop en during DATA of frame with count=3 -> frame finishes; count=4; busy falls after GAP; signal stays 0; no further frame_start until en=1.
5. invert=1 -> every half-bit complemented vs scenario 1; IDLE/GAP line high (after one cycle from reset, which forces 0).
6. Assert rst_n=0 mid-DATA with count=5 -> signal, busy, frame_start go 0 immediately (asynchronously); count=0; on release with en=1, a clean frame with data 0x00 is produced.
